// File: rtl/aes128_iter_ctrl_if.sv
// Request/response bundle for the iterative AES-128 engine.
// 128-bit buses carry FIPS-197 byte 0 in the most significant byte.
interface aes128_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;
  logic [3:0]   round;

  modport slave (
    input  in_valid, in, key, out_ready,
    output in_ready, out_valid, out, busy, round
  );

  modport master (
    output in_valid, in, key, out_ready,
    input  in_ready, out_valid, out, busy, round
  );
endinterface

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// Byte k of every 128-bit value sits at bits [127-8k -: 8] (column-major state).
module aes128_iter_ctrl #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  aes128_iter_ctrl_if.slave bus
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_iter_ctrl supports only NR=10");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int r, c, src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r   = k % 4;
      c   = k / 4;
      src = r + 4*((c + r) % 4);
      o[127-8*k -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return o;
  endfunction

  // RotWord/SubWord on the last word; rcon lands in byte 0 of that word.
  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_rk, r_out;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_out_valid;

  logic         w_last;
  logic [127:0] w_nk, w_sr, w_mid, w_fin;

  assign w_last = (r_round == 4'(NR));
  assign w_nk   = next_key(r_rk, r_rcon);
  assign w_sr   = sub_shift(r_state);
  assign w_mid  = mix_cols(w_sr) ^ w_nk;
  assign w_fin  = w_sr ^ w_nk;

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (bus.in_valid)  w_fsm_nxt = S_ROUND;
      S_ROUND: if (w_last)        w_fsm_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_fsm_nxt = S_IDLE;
      default:                    w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= '0;
      r_rk        <= '0;
      r_rcon      <= '0;
      r_round     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: if (bus.in_valid) begin
          r_state <= bus.in ^ bus.key;
          r_rk    <= bus.key;
          r_rcon  <= 8'h01;
          r_round <= 4'd1;
        end
        S_ROUND: begin
          r_rk   <= w_nk;
          r_rcon <= xtime(r_rcon);
          if (w_last) begin
            r_state     <= w_fin;
            r_out       <= w_fin;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= w_mid;
            r_round <= r_round + 4'd1;
          end
        end
        // out keeps its value after the handshake
        S_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_round     <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_fsm == S_IDLE);
  assign bus.busy      = (r_fsm == S_ROUND) || (r_fsm == S_DONE);
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.round     = r_round;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: FIPS vectors plus random blocks against a
// full-schedule AES reference with a computed (GF inverse + affine) S-box.
module tb_aes128_iter_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes128_iter_ctrl_if bus();

  aes128_iter_ctrl #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0]   sb [256];
  int           acc_q [$];
  int           hs_q  [$];
  logic [127:0] res_q [$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook FIPS-197 encryption with a stored 44-word key schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            if (rd < 10)
              s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            else
              s[4*c+r] = t[4*c+r];
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock; logs accepts, handshakes and handed-off results by cycle.
  task automatic tick();
    logic a, h;
    a = bus.in_valid && bus.in_ready;
    h = bus.out_valid && bus.out_ready;
    if (h) res_q.push_back(bus.out);
    @(posedge clk);
    #1;
    cyc++;
    if (a) acc_q.push_back(cyc);
    if (h) hs_q.push_back(cyc);
  endtask

  task automatic run_one(input string tag, input logic [127:0] k, input logic [127:0] p,
                         input int bp);
    logic [127:0] exp;
    int n;
    exp = aes_ref(k, p);
    bus.key = k; bus.in = p; bus.in_valid = 1'b1; bus.out_ready = (bp == 0);
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    tick();
    bus.in_valid = 1'b0; bus.in = rnd128(); bus.key = rnd128();
    chk({tag, " round_after_accept"}, 128'(bus.round), 128'd1);
    n = 0;
    do begin
      tick(); n++;
      if (!bus.out_valid) chk({tag, " round_count"}, 128'(bus.round), 128'(n + 1));
      bus.in = rnd128(); bus.key = rnd128();
    end while (!bus.out_valid && n < 20);
    chk({tag, " latency"}, 128'(n), 128'd10);
    chk({tag, " out"}, bus.out, exp);
    chk({tag, " busy_done"}, 128'(bus.busy), 128'd1);
    chk({tag, " in_ready_done"}, 128'(bus.in_ready), 128'd0);
    chk({tag, " round_done"}, 128'(bus.round), 128'd10);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, " bp_valid"}, 128'(bus.out_valid), 128'd1);
      chk({tag, " bp_out"}, bus.out, exp);
      chk({tag, " bp_in_ready"}, 128'(bus.in_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk({tag, " hs_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, " hs_in_ready"}, 128'(bus.in_ready), 128'd1);
    chk({tag, " hs_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, " hs_round"}, 128'(bus.round), 128'd0);
    chk({tag, " hs_out_kept"}, bus.out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_valid;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in = '0; bus.key = '0;
    build_sbox();

    chk("model_B", aes_ref(KB, PB), CB);
    chk("model_C1", aes_ref(KC, PC), CC);

    // reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", bus.out, 128'd0);
      chk("rst_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_round", 128'(bus.round), 128'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

    run_one("B", KB, PB, 0);
    run_one("C1", KC, PC, 0);
    run_one("C1_bp", KC, PC, 7);

    // back-to-back with in_valid held and garbage inputs mid-round
    acc_q.delete(); hs_q.delete(); res_q.delete();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.key = KB; bus.in = PB;
    n = 0;
    while (acc_q.size() < 1 && n < 50) begin tick(); n++; end
    bus.key = rnd128(); bus.in = rnd128();
    repeat (3) tick();
    bus.key = KC; bus.in = PC;
    n = 0;
    while (hs_q.size() < 2 && n < 100) begin tick(); n++; end
    bus.in_valid = 1'b0;
    chk("b2b_hs_count", 128'(hs_q.size()), 128'd2);
    chk("b2b_acc_count", 128'(acc_q.size()), 128'd2);
    if (hs_q.size() >= 2 && acc_q.size() >= 2) begin
      chk("b2b_res0", res_q[0], aes_ref(KB, PB));
      chk("b2b_res1", res_q[1], aes_ref(KC, PC));
      chk("b2b_acc_gap", 128'(acc_q[1] - acc_q[0]), 128'd12);
      chk("b2b_hs_lat", 128'(hs_q[0] - acc_q[0]), 128'd11);
    end
    tick();

    // reset at round 5 discards the block
    bus.key = KB; bus.in = PB; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.round != 4'd5 && n < 20) begin tick(); n++; end
    chk("mid_round5", 128'(bus.round), 128'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_busy", 128'(bus.busy), 128'd0);
    chk("mid_round", 128'(bus.round), 128'd0);
    chk("mid_in_ready", 128'(bus.in_ready), 128'd1);
    seen_valid = 1'b0;
    repeat (12) begin tick(); seen_valid |= bus.out_valid; end
    chk("mid_no_stale", 128'(seen_valid), 128'd0);
    run_one("B_after_rst", KB, PB, 0);

    for (int i = 0; i < 6; i++)
      run_one($sformatf("rand%0d", i), rnd128(), rnd128(), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_iter_ctrl.md
Name: aes128_iter_ctrl

Overview:
- Iterative AES-128 encryption engine with a valid/ready front end.
- Accepts one plaintext block and one cipher key, then executes one FIPS-197 round per clock.
- Expands each round key on the fly from the previous one; no full key schedule is stored.
- Sits between the block-request fabric and downstream consumers as the area-efficient sequenced alternative to the fully unrolled combinational cipher; output is bit-identical to that cipher for Nk=4, Nr=10.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  requester has a block and key on in/key
- in_ready  output  1  block is IDLE and can accept
- in  input  128  plaintext [0:127]; byte k = in[8k+:8], column-major state
- key  input  128  cipher key [0:127], same byte order as in
- out_valid  output  1  ciphertext available on out
- out_ready  input  1  consumer accepts out
- out  output  128  ciphertext [0:127], same byte order as in
- busy  output  1  FSM in ROUND or DONE
- round  output  4  current round index, 0 when idle

Behaviour:
- FSM states: IDLE, ROUND, DONE. Reset is synchronous, active-low: at any clk edge with rst_n=0 the FSM goes to IDLE.
- Reset values: out_valid=0, out=0, busy=0, round=0, internal state/round-key/rcon registers=0, in_ready=1 once in IDLE.
- in_ready is decoded from FSM state and is 1 only in IDLE. There is no overlap of operations.
- in/key are sampled only on the edge where in_valid & in_ready (accept edge E0). At all other times they are ignored, and they need not be held after E0.
- At E0:
  - state <= in ^ key
  - rk <= key
  - rcon <= 8'h01
  - round <= 1
  - FSM -> ROUND
- In ROUND, at each edge:
  - Next round key: t = SubWord(RotWord(rk[96+:32])) ^ {rcon,24'h0}; w0 = rk[0+:32]^t, w1 = rk[32+:32]^w0, w2 = rk[64+:32]^w1, w3 = rk[96+:32]^w2.
  - rk <= {w0,w1,w2,w3}.
  - If round<10: state <= MixColumns(ShiftRows(SubBytes(state))) ^ nk, and round++.
  - If round==10: state <= ShiftRows(SubBytes(state)) ^ nk (no MixColumns), FSM -> DONE, out_valid <= 1.
  - rcon <= xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1b,36.
- Latency: out_valid is high after edge E0+10, which is exactly 10 round edges after the accept edge.
- DONE:
  - out = final state, held stable while out_valid=1 and out_ready=0 (unbounded backpressure).
  - On an edge with out_valid & out_ready: out_valid <= 0, FSM -> IDLE, round <= 0. out keeps its last value.
- Throughput with out_ready=1 and in_valid=1: accept E0, result handshake E0+11, next accept E0+12, i.e. 12 cycles per block.
- in_valid asserted while busy has no effect. The request is accepted once in_ready rises, provided in_valid is still high.
- Reset mid-operation (ROUND or DONE) discards the block. The next edge with rst_n=1 starts from IDLE and no stale out_valid is produced.
- SubBytes/SubWord use the FIPS-197 S-box; the team's existing sbox function may be reused.
- MixColumns uses xtime with reduction polynomial 8'h1b.
- No X propagation: every register has a reset value.

Test Plan:
- FIPS-197 App. B vector:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, in=3243f6a8885a308d313198a2e0370734, out_ready=1.
  - Response: out=3925841d02dc09fbdc118597196a0b32; out_valid rises exactly 10 edges after accept; round counts 1..10.
- FIPS-197 App. C.1 vector:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, in=00112233445566778899aabbccddeeff.
  - Response: out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Stimulus: same as C.1, with out_ready=0 for 7 cycles after out_valid rises.
  - Response: out_valid stays 1, out is unchanged, in_ready=0; on out_ready=1 the handshake completes and in_ready=1 on the next cycle.
- Back-to-back and busy-ignore:
  - Stimulus: in_valid held 1 with the App. B then C.1 vectors; in/key changed to garbage mid-ROUND.
  - Response: both correct results, accepts 12 cycles apart; garbage inputs do not affect either result.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge when round=5.
  - Response: next cycle out_valid=0, busy=0, round=0, in_ready=1; a subsequent App. B run gives the correct result.
- Reset values:
  - Stimulus: hold rst_n=0 for 3 edges.
  - Response: out=0, out_valid=0, busy=0, round=0 throughout; in_ready=1 after release.
